// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins ties, but a burst limit guarantees a waiting fetch eventually gets in.
module mem_port_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_valid,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

   state_t     state;
   logic [3:0] burst_cnt;
   logic       grant_data;

   // Data takes the port unless it has already used up its burst allowance
   // while a fetch has been kept waiting.
   assign grant_data = d_req && ((burst_cnt < BURST_LIMIT) || !i_req);

   assign i_stall = i_req & ~i_valid;
   assign d_stall = d_req & ~d_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= 32'd0;
         d_rdata   <= '0;
         i_valid   <= 1'b0;
         d_valid   <= 1'b0;
      end else begin
         i_valid <= 1'b0;
         d_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_data) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  if (i_req)
                     burst_cnt <= (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 4'd1;
                  else
                     burst_cnt <= 4'd0;
               end else if (i_req) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  burst_cnt <= 4'd0;
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  i_rdata <= mem_rdata[31:0];
                  i_valid <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  // A store returns nothing useful, so the last load result is kept.
                  if (!mem_we)
                     d_rdata <= mem_rdata;
                  d_valid <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a timestamp-based reference model.
module tb_mem_port_arbiter;

   localparam int ADDR_W         = 64;
   localparam int DATA_W         = 64;
   localparam int MAX_DATA_BURST = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [31:0]       i_rdata;
   logic              i_valid;
   logic              i_stall;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_BURST(MAX_DATA_BURST)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic        iReq;
      logic [63:0] iAddr;
      logic        dReq;
      logic        dWe;
      logic [63:0] dAddr;
      logic [63:0] dWdata;
      logic [63:0] rdata;
      int          ackDelay;
      logic        expData;
      logic        expWe;
      logic [63:0] expAddr;
      logic [63:0] expWdata;
      logic [31:0] expIRdata;
      logic [63:0] expDRdata;
   } vec_t;

   vec_t vecs[6];
   int   passCount = 0;
   int   checkCount = 0;

   logic [63:0] burstExp[6];

   // Reference model state for the random phase: timestamps and counters only.
   int          lastValid;
   bit          busy;
   bit          ownerD;
   int          ackEdge;
   int          dataRun;
   logic        expWe;
   logic [63:0] expAddr;
   logic [63:0] expWdata;
   logic [63:0] rdataPlan;
   logic [31:0] expIR;
   logic [63:0] expDR;
   bit          expIV;
   bit          expDV;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic iReq, input logic [63:0] iAddr, input logic dReq,
                                input logic dWe, input logic [63:0] dAddr, input logic [63:0] dWdata);
      i_req   = iReq;
      i_addr  = iAddr;
      d_req   = dReq;
      d_we    = dWe;
      d_addr  = dAddr;
      d_wdata = dWdata;
   endtask

   task automatic doReset();
      reset     = 1'b1;
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      mem_ack   = 1'b0;
      mem_rdata = 64'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " mem_req"},   mem_req,   0);
      checkOutput({tag, " mem_we"},    mem_we,    0);
      checkOutput({tag, " mem_addr"},  mem_addr,  0);
      checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, " i_rdata"},   i_rdata,   0);
      checkOutput({tag, " d_rdata"},   d_rdata,   0);
      checkOutput({tag, " i_valid"},   i_valid,   0);
      checkOutput({tag, " d_valid"},   d_valid,   0);
   endtask

   task automatic waitGrant(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic runVector(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      doReset();
      applyStimulus(v.iReq, v.iAddr, v.dReq, v.dWe, v.dAddr, v.dWdata);
      tick();
      checkOutput({t, " mem_req at grant"}, mem_req,   1);
      checkOutput({t, " mem_we"},           mem_we,    v.expWe);
      checkOutput({t, " mem_addr"},         mem_addr,  v.expAddr);
      checkOutput({t, " mem_wdata"},        mem_wdata, v.expWdata);
      checkOutput({t, " i_stall busy"},     i_stall,   v.iReq);
      checkOutput({t, " d_stall busy"},     d_stall,   v.dReq);
      mem_rdata = v.rdata;
      for (int c = 1; c < v.ackDelay; c++) begin
         tick();
         checkOutput($sformatf("%s wait%0d mem_req", t, c),  mem_req,   1);
         checkOutput($sformatf("%s wait%0d mem_addr", t, c), mem_addr,  v.expAddr);
         checkOutput($sformatf("%s wait%0d mem_we", t, c),   mem_we,    v.expWe);
         checkOutput($sformatf("%s wait%0d mem_wdata", t, c), mem_wdata, v.expWdata);
         checkOutput($sformatf("%s wait%0d valid", t, c),    {i_valid, d_valid}, 2'b00);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput({t, " i_valid"},        i_valid, !v.expData);
      checkOutput({t, " d_valid"},        d_valid, v.expData);
      checkOutput({t, " mem_req in resp"}, mem_req, 0);
      checkOutput({t, " i_rdata"},        i_rdata, v.expIRdata);
      checkOutput({t, " d_rdata"},        d_rdata, v.expDRdata);
      checkOutput({t, " i_stall resp"},   i_stall, v.iReq && v.expData);
      checkOutput({t, " d_stall resp"},   d_stall, v.dReq && !v.expData);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      tick();
      checkOutput({t, " single pulse"}, {i_valid, d_valid}, 2'b00);
   endtask

   initial begin
      vecs[0] = '{1'b1, 64'h0,  1'b0, 1'b0, 64'h0,  64'h0,  64'h00500093, 1,
                  1'b0, 1'b0, 64'h0,  64'h0,  32'h00500093, 64'h0};
      vecs[1] = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h10, 64'h0,  64'hDEADBEEF, 1,
                  1'b1, 1'b0, 64'h10, 64'h0,  32'h0, 64'hDEADBEEF};
      vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h8,  64'h2A, 64'h1234, 2,
                  1'b1, 1'b1, 64'h8,  64'h2A, 32'h0, 64'h0};
      vecs[3] = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0,  64'h0,  64'hCAFEBABE_11223344, 5,
                  1'b0, 1'b0, 64'h40, 64'h0,  32'h11223344, 64'h0};
      vecs[4] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h18, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 3,
                  1'b1, 1'b0, 64'h18, 64'h55, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[5] = '{1'b1, 64'h80, 1'b1, 1'b1, 64'h20, 64'h77, 64'h9, 1,
                  1'b1, 1'b1, 64'h20, 64'h77, 32'h0, 64'h0};
      burstExp[0] = 64'h200; burstExp[1] = 64'h208; burstExp[2] = 64'h210;
      burstExp[3] = 64'h218; burstExp[4] = 64'h100; burstExp[5] = 64'h220;

      doReset();
      checkAllZero("reset");
      checkOutput("reset i_stall", i_stall, 0);
      checkOutput("reset d_stall", d_stall, 0);

      for (int v = 0; v < 6; v++)
         runVector(vecs[v], v);

      // Data wins a tie; fetch follows in the IDLE cycle after data's RESP.
      doReset();
      applyStimulus(1'b1, 64'h4, 1'b1, 1'b0, 64'h10, 64'h0);
      tick();
      checkOutput("tie data first addr", mem_addr, 64'h10);
      checkOutput("tie i_stall busy_d", i_stall, 1);
      mem_rdata = 64'hDEADBEEF;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("tie d_valid", d_valid, 1);
      checkOutput("tie d_rdata", d_rdata, 64'hDEADBEEF);
      checkOutput("tie i_stall resp", i_stall, 1);
      applyStimulus(1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 64'h0);
      tick();
      checkOutput("tie no grant after resp", mem_req, 0);
      checkOutput("tie i_stall idle", i_stall, 1);
      tick();
      checkOutput("tie fetch grant", mem_req, 1);
      checkOutput("tie fetch addr", mem_addr, 64'h4);
      checkOutput("tie fetch we", mem_we, 0);
      mem_rdata = 64'h13;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("tie i_valid", i_valid, 1);
      checkOutput("tie i_rdata", i_rdata, 32'h13);
      checkOutput("tie i_stall low", i_stall, 0);

      // Sustained data traffic with a fetch waiting: four data grants, then the fetch.
      doReset();
      applyStimulus(1'b1, 64'h100, 1'b1, 1'b0, 64'h200, 64'h0);
      for (int g = 0; g < 6; g++) begin
         bit ok;
         waitGrant(ok);
         checkOutput($sformatf("burst grant%0d arrived", g), ok, 1);
         if (!ok) break;
         checkOutput($sformatf("burst grant%0d addr", g), mem_addr, burstExp[g]);
         mem_ack = 1'b1;
         mem_rdata = 64'(g);
         tick();
         mem_ack = 1'b0;
         if (g == 4) i_addr = 64'h104;
         else        d_addr = d_addr + 64'h8;
      end

      // Reset in the middle of a data access; the late ack must be ignored.
      doReset();
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h30, 64'h0);
      tick();
      checkOutput("midreset busy", mem_req, 1);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkAllZero("midreset");
      tick();
      mem_rdata = 64'hFFFF;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("stray ack d_valid", d_valid, 0);
      checkOutput("stray ack mem_req", mem_req, 0);
      tick();
      checkOutput("stray ack d_valid later", d_valid, 0);
      checkOutput("stray ack d_rdata", d_rdata, 0);

      // Randomized traffic against the timestamp model.
      doReset();
      lastValid = -10;
      busy      = 1'b0;
      ownerD    = 1'b0;
      ackEdge   = 0;
      dataRun   = 0;
      expIR     = 32'h0;
      expDR     = 64'h0;
      expWe     = 1'b0;
      expAddr   = 64'h0;
      expWdata  = 64'h0;
      rdataPlan = 64'h0;
      for (int k = 1; k <= 3000; k++) begin
         tick();
         expIV = 1'b0;
         expDV = 1'b0;
         if (busy) begin
            if (k == ackEdge) begin
               busy = 1'b0;
               lastValid = k;
               if (ownerD) begin
                  expDV = 1'b1;
                  if (!expWe) expDR = rdataPlan;
               end else begin
                  expIV = 1'b1;
                  expIR = rdataPlan[31:0];
               end
            end
         end else if (k >= lastValid + 2 && (i_req || d_req)) begin
            if (d_req && (dataRun < MAX_DATA_BURST || !i_req)) begin
               ownerD   = 1'b1;
               expWe    = d_we;
               expAddr  = d_addr;
               expWdata = d_wdata;
               dataRun  = i_req ? ((dataRun + 1 > MAX_DATA_BURST) ? MAX_DATA_BURST : dataRun + 1) : 0;
            end else begin
               ownerD   = 1'b0;
               expWe    = 1'b0;
               expAddr  = i_addr;
               expWdata = 64'h0;
               dataRun  = 0;
            end
            busy = 1'b1;
            ackEdge = k + int'($urandom_range(1, 4));
            rdataPlan = {$urandom(), $urandom()};
         end
         checkOutput($sformatf("rnd%0d mem_req", k), mem_req, busy);
         if (busy) begin
            checkOutput($sformatf("rnd%0d mem_addr", k),  mem_addr,  expAddr);
            checkOutput($sformatf("rnd%0d mem_we", k),    mem_we,    expWe);
            checkOutput($sformatf("rnd%0d mem_wdata", k), mem_wdata, expWdata);
         end
         checkOutput($sformatf("rnd%0d i_valid", k), i_valid, expIV);
         checkOutput($sformatf("rnd%0d d_valid", k), d_valid, expDV);
         checkOutput($sformatf("rnd%0d i_rdata", k), i_rdata, expIR);
         checkOutput($sformatf("rnd%0d d_rdata", k), d_rdata, expDR);
         checkOutput($sformatf("rnd%0d i_stall", k), i_stall, i_req && !expIV);
         checkOutput($sformatf("rnd%0d d_stall", k), d_stall, d_req && !expDV);

         if (busy) begin
            mem_ack   = (k + 1 == ackEdge);
            mem_rdata = (k + 1 == ackEdge) ? rdataPlan : {$urandom(), $urandom()};
         end else begin
            mem_ack   = ($urandom_range(0, 7) == 0);
            mem_rdata = {$urandom(), $urandom()};
         end

         if (expIV) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = {$urandom(), $urandom()};
         end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = {$urandom(), $urandom()};
         end
         if (expDV) begin
            d_req   = ($urandom_range(0, 4) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = {$urandom(), $urandom()};
            d_wdata = {$urandom(), $urandom()};
         end else if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req   = 1'b1;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = {$urandom(), $urandom()};
            d_wdata = {$urandom(), $urandom()};
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
